// File: rtl/estagio_if_pkg.sv
// Shared pipeline definitions: widths, NOP word, IF-stage states and the IF/ID payload.
package estagio_if_pkg;
  localparam int IW = 32;
  localparam int AW = 32;
  localparam logic [IW-1:0] NOP_WORD = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic [1:0] {
    INICIO   = 2'd0,
    ESPERA   = 2'd1,
    RETIDO   = 2'd2,
    DESCARTA = 2'd3
  } estado_e;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc4;
    logic          valido;
  } ifid_t;

  function automatic logic [AW-1:0] alinha(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/estagio_if_registrador_if_id.sv
// Generic inter-stage register: flush beats load, load beats hold; resets to a bubble.
module registrador_if_id
  import estagio_if_pkg::*;
#(
  parameter logic [IW-1:0] NOP = NOP_WORD
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  load_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);
  ifid_t q_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     q_q <= '{instr: NOP, pc4: '0, valido: 1'b0};
    else if (flush_i) q_q <= '{instr: NOP, pc4: '0, valido: 1'b0};
    else if (load_i)  q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

// File: rtl/estagio_if.sv
// Instruction-fetch stage: PC, req/ack fetch FSM with a one-entry skid buffer, IF/ID register.
module estagio_if
  import estagio_if_pkg::*;
#(
  parameter logic [AW-1:0] PC_RESET = 32'h0000_0000,
  parameter logic [IW-1:0] NOP      = NOP_WORD
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          stall,
  input  logic          desvio,
  input  logic [AW-1:0] alvo,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_dado,
  output logic [IW-1:0] instrucao,
  output logic [AW-1:0] PC4ID,
  output logic          valido
);
  estado_e       state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  logic [IW-1:0] buf_instr_q, buf_instr_d;
  logic [AW-1:0] buf_pc4_q, buf_pc4_d;

  logic          ifid_load, ifid_flush;
  ifid_t         ifid_d, ifid_q;
  logic          ack_v;
  logic [AW-1:0] alvo_a;

  // An ack is only meaningful while a request is outstanding.
  assign ack_v  = imem_ack & req_q;
  assign alvo_a = alinha(alvo);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INICIO;
      pc_q        <= PC_RESET;
      addr_q      <= PC_RESET;
      req_q       <= 1'b0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    req_d       = req_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;
    ifid_d      = '{instr: imem_dado, pc4: addr_q + 32'd4, valido: 1'b1};

    unique case (state_q)
      INICIO: begin
        state_d = ESPERA;
        req_d   = 1'b1;
        if (desvio) begin
          pc_d   = alvo_a;
          addr_d = alvo_a;
        end else begin
          addr_d = pc_q;
        end
      end

      ESPERA: begin
        if (desvio) begin
          pc_d        = alvo_a;
          ifid_flush  = 1'b1;
          buf_instr_d = '0;
          buf_pc4_d   = '0;
          // The address may not move mid-handshake: drain the old fetch first.
          if (ack_v) addr_d  = alvo_a;
          else       state_d = DESCARTA;
        end else if (ack_v && !stall) begin
          ifid_load = 1'b1;
          pc_d      = addr_q + 32'd4;
          addr_d    = addr_q + 32'd4;
        end else if (ack_v) begin
          buf_instr_d = imem_dado;
          buf_pc4_d   = addr_q + 32'd4;
          req_d       = 1'b0;
          state_d     = RETIDO;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end

      RETIDO: begin
        if (desvio) begin
          pc_d        = alvo_a;
          ifid_flush  = 1'b1;
          buf_instr_d = '0;
          buf_pc4_d   = '0;
          req_d       = 1'b1;
          addr_d      = alvo_a;
          state_d     = ESPERA;
        end else if (!stall) begin
          ifid_d    = '{instr: buf_instr_q, pc4: buf_pc4_q, valido: 1'b1};
          ifid_load = 1'b1;
          pc_d      = pc_q + 32'd4;
          addr_d    = pc_q + 32'd4;
          req_d     = 1'b1;
          state_d   = ESPERA;
        end
      end

      DESCARTA: begin
        ifid_flush = 1'b1;
        if (desvio) pc_d = alvo_a;
        if (ack_v) begin
          addr_d  = desvio ? alvo_a : pc_q;
          state_d = ESPERA;
        end
      end

      default: state_d = INICIO;
    endcase
  end

  registrador_if_id #(.NOP(NOP)) u_if_id (
    .clk_i   (clock),
    .rst_n_i (reset_n),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign instrucao = ifid_q.instr;
  assign PC4ID     = ifid_q.pc4;
  assign valido    = ifid_q.valido;
endmodule
